// File: rtl/lnrv_ifu_flush.sv
// Flush responder inside the IFU: accepts a flush request, blocks and drains
// in-flight fetches, then presents exactly one redirect PC to the PC generator.
module lnrv_ifu_flush #(
    parameter int OSTD_DEPTH = 2,
    parameter int CNT_W      = $clog2(OSTD_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pipe_flush_req,
    output logic             pipe_flush_ack,
    input  logic [31:0]      pipe_flush_pc_op1,
    input  logic [31:0]      pipe_flush_pc_op2,
    input  logic             ifu_cmd_hsked,
    input  logic             ifu_rsp_hsked,
    output logic             fetch_hold,
    output logic             rsp_kill,
    output logic             flush_busy,
    output logic             redirect_vld,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_rdy,
    output logic [1:0]       state_dbg,
    output logic [CNT_W-1:0] ostd_cnt_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid (req/vld) and
    // ready (ack/rdy) are both high; the initiator holds valid and payload
    // stable until then, and ready never depends on valid.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] ostd_cnt;
    logic [CNT_W-1:0] next_cnt;
    logic [31:0]      target;
    logic             cnt_full;
    logic             cnt_empty;
    logic             flush_hs;

    assign cnt_full  = (ostd_cnt == CNT_W'(OSTD_DEPTH));
    assign cnt_empty = (ostd_cnt == '0);
    assign flush_hs  = pipe_flush_req & (state == IDLE);

    // Saturate rather than wrap if the bus misbehaves.
    always_comb begin
        next_cnt = ostd_cnt;
        if (ifu_cmd_hsked && !ifu_rsp_hsked && !cnt_full)
            next_cnt = ostd_cnt + CNT_W'(1);
        else if (ifu_rsp_hsked && !ifu_cmd_hsked && !cnt_empty)
            next_cnt = ostd_cnt - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ostd_cnt     <= '0;
            target       <= '0;
            redirect_vld <= 1'b0;
        end else begin
            ostd_cnt <= next_cnt;
            case (state)
                IDLE: begin
                    if (flush_hs) begin
                        target <= pipe_flush_pc_op1 + pipe_flush_pc_op2;
                        if (next_cnt == '0) begin
                            state        <= REDIRECT;
                            redirect_vld <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (next_cnt == '0) begin
                        state        <= REDIRECT;
                        redirect_vld <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (redirect_rdy) begin
                        state        <= IDLE;
                        redirect_vld <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    redirect_vld <= 1'b0;
                end
            endcase
        end
    end

    assign pipe_flush_ack = (state == IDLE);
    assign flush_busy     = (state != IDLE);
    assign fetch_hold     = (state != IDLE) | cnt_full;
    // Only DRAIN responses are stale; a handshake-cycle response belongs to the old stream.
    assign rsp_kill       = ifu_rsp_hsked & (state == DRAIN);
    assign redirect_pc    = target;
    assign state_dbg      = state;
    assign ostd_cnt_dbg   = ostd_cnt;

    a_no_cnt_overflow : assert property (@(posedge clk) disable iff (!reset_n)
        !(ifu_cmd_hsked && !ifu_rsp_hsked && cnt_full));
    a_no_cnt_underflow : assert property (@(posedge clk) disable iff (!reset_n)
        !(ifu_rsp_hsked && !ifu_cmd_hsked && cnt_empty));

endmodule

// File: tb/tb_lnrv_ifu_flush.sv
// Bench for lnrv_ifu_flush: directed flush scenarios plus random traffic,
// checked each cycle against a transaction-level model and a redirect-PC queue.
module tb_lnrv_ifu_flush;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pipe_flush_req = 1'b0;
    logic          pipe_flush_ack;
    logic [31:0]   pipe_flush_pc_op1 = '0;
    logic [31:0]   pipe_flush_pc_op2 = '0;
    logic          ifu_cmd_hsked = 1'b0;
    logic          ifu_rsp_hsked = 1'b0;
    logic          fetch_hold;
    logic          rsp_kill;
    logic          flush_busy;
    logic          redirect_vld;
    logic [31:0]   redirect_pc;
    logic          redirect_rdy = 1'b0;
    logic [1:0]    state_dbg;
    logic [CW-1:0] ostd_cnt_dbg;

    lnrv_ifu_flush #(.OSTD_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .pipe_flush_req    (pipe_flush_req),
        .pipe_flush_ack    (pipe_flush_ack),
        .pipe_flush_pc_op1 (pipe_flush_pc_op1),
        .pipe_flush_pc_op2 (pipe_flush_pc_op2),
        .ifu_cmd_hsked     (ifu_cmd_hsked),
        .ifu_rsp_hsked     (ifu_rsp_hsked),
        .fetch_hold        (fetch_hold),
        .rsp_kill          (rsp_kill),
        .flush_busy        (flush_busy),
        .redirect_vld      (redirect_vld),
        .redirect_pc       (redirect_pc),
        .redirect_rdy      (redirect_rdy),
        .state_dbg         (state_dbg),
        .ostd_cnt_dbg      (ostd_cnt_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Model: fetches outstanding, a flush accepted but not yet redirected,
    // and whether the redirect is being offered.
    int m_cnt   = 0;
    bit m_flush = 1'b0;
    bit m_vld   = 1'b0;
    bit hs_flag = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks mid-cycle, then advances the model across the coming edge.
    always @(negedge clk) begin
        int nc;
        if (reset_n) begin
            chk("ack",      32'(pipe_flush_ack), 32'(!m_flush));
            chk("busy",     32'(flush_busy),     32'(m_flush));
            chk("hold",     32'(fetch_hold),     32'(m_flush || m_cnt == DEPTH));
            chk("kill",     32'(rsp_kill),       32'(ifu_rsp_hsked && m_flush && !m_vld));
            chk("vld",      32'(redirect_vld),   32'(m_vld));
            chk("ostd_cnt", 32'(ostd_cnt_dbg),   32'(m_cnt));
            if (m_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL redirect_pc: got 0x%08h with no expected target queued", redirect_pc);
                end else begin
                    chk("redirect_pc", redirect_pc, exp_q[0]);
                    if (redirect_rdy) void'(exp_q.pop_front());
                end
            end
            nc = m_cnt + int'(ifu_cmd_hsked) - int'(ifu_rsp_hsked);
            if (!m_flush) begin
                if (pipe_flush_req) begin
                    m_flush = 1'b1;
                    m_vld   = (nc == 0);
                    hs_flag = 1'b1;
                end
            end else if (!m_vld) begin
                m_vld = (nc == 0);
            end else if (redirect_rdy) begin
                m_flush = 1'b0;
                m_vld   = 1'b0;
            end
            m_cnt = nc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (hs_flag) begin
            pipe_flush_req = 1'b0;
            hs_flag = 1'b0;
        end
    endtask

    task automatic set_req(input logic [31:0] op1, input logic [31:0] op2);
        pipe_flush_req    = 1'b1;
        pipe_flush_pc_op1 = op1;
        pipe_flush_pc_op2 = op2;
        exp_q.push_back(op1 + op2);
    endtask

    task automatic drv(input bit cmd, input bit rsp, input bit rdy);
        ifu_cmd_hsked = cmd;
        ifu_rsp_hsked = rsp;
        redirect_rdy  = rdy;
        step();
    endtask

    initial begin
        int budget;
        #12;
        chk("reset_ack",  32'(pipe_flush_ack), 32'd1);
        chk("reset_vld",  32'(redirect_vld),   32'd0);
        chk("reset_pc",   redirect_pc,         32'd0);
        chk("reset_hold", 32'(fetch_hold),     32'd0);
        reset_n = 1'b1;
        step();

        // Idle flush
        set_req(32'h800, 32'h0);
        drv(0, 0, 1); drv(0, 0, 1); drv(0, 0, 0);

        // Drain two outstanding fetches, responses at +2 and +4
        drv(1, 0, 0); drv(1, 0, 0);
        set_req(32'h1000, 32'h234);
        drv(0, 0, 0); drv(0, 0, 0); drv(0, 1, 0); drv(0, 0, 0); drv(0, 1, 0);
        drv(0, 0, 1); drv(0, 0, 0);

        // Command and response together in the handshake cycle
        drv(1, 0, 0);
        set_req(32'h40, 32'h4);
        drv(1, 1, 0); drv(0, 0, 0); drv(0, 1, 0); drv(0, 0, 1); drv(0, 0, 0);

        // Modulo-2^32 target
        set_req(32'hFFFF_FFFC, 32'h8);
        drv(0, 0, 1); drv(0, 0, 1); drv(0, 0, 0);

        // Redirect backpressure with a second request waiting
        set_req(32'h2000, 32'h0);
        drv(0, 0, 0);
        set_req(32'h3000, 32'h10);
        drv(0, 0, 0); drv(0, 0, 0); drv(0, 0, 0);
        drv(0, 0, 1); drv(0, 0, 1); drv(0, 0, 1); drv(0, 0, 0);

        // Asynchronous reset while draining
        drv(1, 0, 0); drv(1, 0, 0);
        set_req(32'h5000, 32'h0);
        drv(0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_vld",  32'(redirect_vld),   32'd0);
        chk("rst_busy", 32'(flush_busy),     32'd0);
        chk("rst_hold", 32'(fetch_hold),     32'd0);
        chk("rst_ack",  32'(pipe_flush_ack), 32'd1);
        pipe_flush_req = 1'b0;
        ifu_cmd_hsked  = 1'b0;
        ifu_rsp_hsked  = 1'b0;
        redirect_rdy   = 1'b0;
        m_cnt = 0; m_flush = 1'b0; m_vld = 1'b0; hs_flag = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        step();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (!pipe_flush_req && $urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    set_req(32'hFFFF_FF00 | 32'($urandom_range(0, 255)), 32'($urandom_range(0, 1023)));
                else
                    set_req($urandom(), $urandom());
            end
            ifu_cmd_hsked = (!m_flush && m_cnt < DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0;
            ifu_rsp_hsked = (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
            redirect_rdy  = 1'($urandom_range(0, 1));
            step();
        end

        // Let everything settle, bounded
        budget = 0;
        while ((m_flush || m_cnt != 0 || pipe_flush_req) && budget < 50) begin
            drv(0, m_cnt > 0, 1);
            budget++;
        end
        if (budget >= 50) begin
            checks++;
            errors++;
            $display("FAIL settle_timeout: flush still pending after %0d cycles", budget);
        end
        drv(0, 0, 0);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lnrv_ifu_flush.md
Name: lnrv_ifu_flush

Overview:
Responder end of the pipeline-flush handshake. Accepts a flush request (target = op1 + op2) from any EXU requester, e.g. debug entry, trap or branch. It then blocks new instruction fetches, drains and discards in-flight fetch responses, and issues a single redirect PC to the IFU PC generator. Sits in the IFU, between the flush requesters and the fetch bus/PC logic.

Parameters:
OSTD_DEPTH, 2, maximum number of outstanding fetch commands on the instruction bus (>=1).
CNT_W, $clog2(OSTD_DEPTH+1), width of the outstanding-fetch counter (derived; do not override).

Ports:
clk  input  1  core clock
reset_n  input  1  reset; one clock; asynchronous, active-low
pipe_flush_req  input  1  flush request from EXU; held until acked
pipe_flush_ack  output  1  flush accepted; handshake = req & ack
pipe_flush_pc_op1  input  32  target PC operand 1
pipe_flush_pc_op2  input  32  target PC operand 2
ifu_cmd_hsked  input  1  fetch command accepted by bus this cycle
ifu_rsp_hsked  input  1  fetch response accepted from bus this cycle
fetch_hold  output  1  blocks issue of new fetch commands
rsp_kill  output  1  current response is stale; IFU must not forward it to decode
flush_busy  output  1  flush in progress (state != IDLE)
redirect_vld  output  1  redirect PC valid
redirect_pc  output  32  new fetch PC
redirect_rdy  input  1  PC generator accepts redirect

Behaviour:
- Reset values: state=IDLE, ostd_cnt=0, target=0, redirect_vld=0, redirect_pc=0, flush_busy=0, rsp_kill=0. pipe_flush_ack=1. fetch_hold=0.
- pipe_flush_ack = (state==IDLE). It is combinational from state only and never depends on req.
- Flush handshake: target <= op1 + op2, 32-bit modulo with carry discarded, captured on the handshake edge.
- ostd_cnt: +1 on cmd_hsked only; -1 on rsp_hsked only; unchanged when both or neither. next_cnt denotes the post-update value.
- fetch_hold = (state != IDLE) | (ostd_cnt == OSTD_DEPTH).
  - Commands in the handshake cycle itself are still allowed (state still IDLE) and are counted, then drained.
- rsp_kill = ifu_rsp_hsked & (state == DRAIN).
  - A response in the handshake cycle is not killed; it belongs to the old stream and the requester guarantees the stream is idle.
- FSM:
  - IDLE: on handshake -> REDIRECT if next_cnt==0, else DRAIN.
  - DRAIN: stay while next_cnt != 0; -> REDIRECT when next_cnt==0. Last response in the same cycle counts as drained.
  - REDIRECT: redirect_vld=1, redirect_pc=target, both held stable until redirect_rdy. On vld&rdy -> IDLE.
- Latency: with ostd_cnt==0 at handshake, redirect_vld rises the cycle after the handshake. Each outstanding response adds at least one cycle.
- flush_busy = (state != IDLE). Combinational from state.
- Back-to-back flushes: a second req is not acked until IDLE is re-entered. Earliest second handshake is the cycle after the redirect handshake.
- Error guard: cmd_hsked while ostd_cnt==OSTD_DEPTH, or rsp_hsked while ostd_cnt==0, must not wrap the counter. It saturates at OSTD_DEPTH / 0. Simulation assertion fires.
- Async reset mid-flush: returns to IDLE immediately. The pending target is lost, redirect_vld drops, and the counter clears.

Test Plan:
- Idle flush: ostd_cnt=0; req with op1=0x800, op2=0 -> ack=1 same cycle; next cycle redirect_vld=1, pc=0x800; rdy=1 -> IDLE, ack=1 following cycle.
- Drain: 2 fetches outstanding; flush handshake; responses on cycles +2 and +4 -> rsp_kill=1 on both, fetch_hold=1 throughout; redirect_vld rises cycle +5.
- Same-cycle events: ostd_cnt=1; handshake cycle has cmd_hsked=1 and rsp_hsked=1 -> that response not killed; cnt stays 1; state=DRAIN; next rsp killed, then REDIRECT.
- Wrap arithmetic: op1=0xFFFF_FFFC, op2=0x8 -> redirect_pc=0x0000_0004.
- Backpressure + second request: redirect_rdy=0 for 3 cycles with req held -> redirect_vld/pc stable, ack=0; rdy=1 -> IDLE; second req acked next cycle with new target.
- Reset mid-DRAIN: assert reset_n=0 asynchronously -> redirect_vld=0, flush_busy=0, fetch_hold=0, ack=1 without a clock edge; counter reads 0 after release.
